// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that grants one requester at a time for up to maxb beats
// and forwards its data through a single registered output slot.
module mux_rr_arbiter #(
  parameter int unsigned m     = 8,
  parameter int unsigned n     = 8,
  parameter int unsigned width = 3,
  parameter int unsigned maxb  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [n*m-1:0]     pdata,
  input  logic [n-1:0]       req_v,
  output logic [n-1:0]       req_r,
  output logic [m-1:0]       data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width-1:0]   sel_o,
  output logic               busy_o
);

  localparam int unsigned CW = $clog2(maxb + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [width-1:0] r_ptr, w_ptr_nxt;
  logic [width-1:0] r_g, w_g_nxt;
  logic [CW-1:0]    r_beat_cnt, w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;
  logic [m-1:0]     r_data;
  logic             r_valid;

  logic             w_free;
  logic             w_req_g;
  logic             w_accept;
  logic             w_found;
  logic [width-1:0] w_pick;
  logic [m-1:0]     w_slice;

  // Mux the granted requester's valid and data slice.
  always_comb begin
    w_req_g = 1'b0;
    w_slice = '0;
    for (int unsigned i = 0; i < n; i++) begin
      if (r_g == width'(i)) begin
        w_req_g = req_v[i];
        w_slice = pdata[i*m +: m];
      end
    end
  end

  // Rotating priority: first pass covers ptr..n-1, second pass wraps to 0..ptr-1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 0; i < n; i++) begin
      if (!w_found && req_v[i] && (width'(i) >= r_ptr)) begin
        w_found = 1'b1;
        w_pick  = width'(i);
      end
    end
    for (int unsigned i = 0; i < n; i++) begin
      if (!w_found && req_v[i]) begin
        w_found = 1'b1;
        w_pick  = width'(i);
      end
    end
  end

  assign w_free    = !r_valid || ready_i;
  assign w_accept  = (r_state == BUSY) && w_free && w_req_g;
  assign w_cnt_inc = r_beat_cnt + CW'(1);

  always_comb begin
    req_r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      req_r[i] = (r_state == BUSY) && w_free && (r_g == width'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_g_nxt     = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_accept) begin
          w_cnt_nxt = w_cnt_inc;
        end
        // A dropped request releases even with zero beats taken.
        if (!w_req_g || (w_accept && (w_cnt_inc == CW'(maxb)))) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = (r_g == width'(n - 1)) ? '0 : r_g + width'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_g        <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_g        <= w_g_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= w_slice;
      r_valid <= 1'b1;
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign sel_o   = r_g;
  assign busy_o  = (r_state == BUSY);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: cycle model compared every negedge, plus directed
// scenarios with literal expectations.
module tb_mux_rr_arbiter;

  localparam int M    = 8;
  localparam int N    = 8;
  localparam int W    = 3;
  localparam int MAXB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*M-1:0] pdata;
  logic [N-1:0]   req_v;
  logic [N-1:0]   req_r;
  logic [M-1:0]   data_o;
  logic           valid_o;
  logic           ready_i;
  logic [W-1:0]   sel_o;
  logic           busy_o;

  mux_rr_arbiter #(.m(M), .n(N), .width(W), .maxb(MAXB)) dut (
    .clk(clk), .rst(rst), .pdata(pdata), .req_v(req_v), .req_r(req_r),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .sel_o(sel_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: arbiter as a grant owner plus a one-deep output slot.
  bit         m_started = 1'b0;
  bit         m_busy, m_valid;
  int         m_g, m_ptr, m_cnt;
  logic [M-1:0] m_data;
  int         cyc = 0;
  int         g_log[$];
  int         cyc_log[$];
  int         rel_beats[$];

  function automatic int pick(input logic [N-1:0] rv, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (rv[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  logic x_free, x_acc, x_rel;
  int   x_pick;
  always_comb begin
    x_free = !m_valid || ready_i;
    x_acc  = m_busy && x_free && req_v[m_g];
    x_pick = pick(req_v, m_ptr);
    x_rel  = m_busy && (!req_v[m_g] || (x_acc && (m_cnt + 1 == MAXB)));
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      m_started <= 1'b1;
      m_busy    <= 1'b0;
      m_valid   <= 1'b0;
      m_g       <= 0;
      m_ptr     <= 0;
      m_cnt     <= 0;
      m_data    <= '0;
    end else if (m_started) begin
      if (!m_busy && x_pick >= 0) begin
        m_busy <= 1'b1;
        m_g    <= x_pick;
        m_cnt  <= 0;
        g_log.push_back(x_pick);
        cyc_log.push_back(cyc);
      end
      if (x_acc) m_cnt <= m_cnt + 1;
      if (x_rel) begin
        m_busy <= 1'b0;
        m_ptr  <= (m_g + 1) % N;
        rel_beats.push_back(m_cnt + (x_acc ? 1 : 0));
      end
      if (x_acc) begin
        m_valid <= 1'b1;
        m_data  <= pdata[m_g*M +: M];
      end else if (m_valid && ready_i) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("busy_o", 64'(busy_o), 64'(m_busy));
      chk("valid_o", 64'(valid_o), 64'(m_valid));
      chk("data_o", 64'(data_o), 64'(m_data));
      chk("sel_o", 64'(sel_o), 64'(m_g));
      chk("req_r", 64'(req_r), (m_busy && x_free) ? (64'd1 << m_g) : 64'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_v = '0; ready_i = 1'b1;
    pdata = 64'h7766_5544_33A5_1100;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_sel", 64'(sel_o), 0);
    chk("rst_req_r", 64'(req_r), 0);
    chk("rst_data", 64'(data_o), 0);

    // Single requester 2
    req_v = 8'h04;
    tick; #1;
    chk("s1_busy", 64'(busy_o), 1);
    chk("s1_sel", 64'(sel_o), 2);
    chk("s1_req_r", 64'(req_r), 64'h04);
    tick; #1;
    chk("s1_valid", 64'(valid_o), 1);
    chk("s1_data", 64'(data_o), 64'hA5);
    tick; tick; tick; #1;
    chk("s1_release", 64'(busy_o), 0);
    chk("s1_ptr", 64'(m_ptr), 3);
    req_v = '0;
    tick; #1;
    chk("s1_drain", 64'(valid_o), 0);

    // Fairness with all requesting
    rst = 1'b1; tick; rst = 1'b0;
    chk("s2_ptr0", 64'(m_ptr), 0);
    g_log.delete(); cyc_log.delete(); rel_beats.delete();
    req_v = 8'hFF;
    for (int t = 0; t < 60 && g_log.size() < 9; t++) tick;
    chk("s2_grants", 64'(g_log.size()), 9);
    for (int k = 0; k < 9 && k < g_log.size(); k++) chk("s2_order", 64'(g_log[k]), 64'(k % 8));
    for (int k = 0; k < 8 && k < rel_beats.size(); k++) chk("s2_beats", 64'(rel_beats[k]), 4);
    for (int k = 0; k < 8 && k + 1 < cyc_log.size(); k++)
      chk("s2_gap", 64'(cyc_log[k+1] - cyc_log[k]), 5);
    req_v = '0;
    tick; tick;

    // Backpressure on grant 5
    rst = 1'b1; tick; rst = 1'b0;
    req_v = 8'h20;
    tick; #1;
    chk("s3_sel", 64'(sel_o), 5);
    chk("s3_req_r", 64'(req_r), 64'h20);
    tick;
    ready_i = 1'b0;
    pdata[47:40] = 8'hC3;
    #1;
    chk("s3_data1", 64'(data_o), 64'h55);
    chk("s3_stall_r", 64'(req_r), 0);
    for (int k = 0; k < 3; k++) begin
      tick; #1;
      chk("s3_hold_r", 64'(req_r), 0);
      chk("s3_hold_d", 64'(data_o), 64'h55);
      chk("s3_hold_v", 64'(valid_o), 1);
    end
    ready_i = 1'b1;
    #1;
    chk("s3_resume_r", 64'(req_r), 64'h20);
    tick; #1;
    chk("s3_data2", 64'(data_o), 64'hC3);
    req_v = '0;
    tick; #1;
    chk("s3_release", 64'(busy_o), 0);
    chk("s3_ptr", 64'(m_ptr), 6);

    // Early release of grant 1 after two beats
    req_v = 8'h02;
    tick; #1;
    chk("s4_sel", 64'(sel_o), 1);
    tick; tick; #1;
    chk("s4_data", 64'(data_o), 64'h11);
    req_v = '0;
    tick; #1;
    chk("s4_idle", 64'(busy_o), 0);
    chk("s4_ptr", 64'(m_ptr), 2);
    if (rel_beats.size() > 0) chk("s4_beats", 64'(rel_beats[rel_beats.size()-1]), 2);

    // Wrap-around from 7 back to 0
    req_v = 8'h80;
    tick; #1;
    chk("s5_sel7", 64'(sel_o), 7);
    req_v = 8'h81;
    tick; tick; tick; tick; #1;
    chk("s5_release", 64'(busy_o), 0);
    chk("s5_ptr", 64'(m_ptr), 0);
    tick; #1;
    chk("s5_sel0", 64'(sel_o), 0);
    chk("s5_busy", 64'(busy_o), 1);

    // Reset mid-burst with a beat in the output slot
    tick; #1;
    chk("s6_valid", 64'(valid_o), 1);
    chk("s6_data", 64'(data_o), 64'h00);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("s6_valid0", 64'(valid_o), 0);
    chk("s6_busy0", 64'(busy_o), 0);
    chk("s6_sel0", 64'(sel_o), 0);
    chk("s6_req_r0", 64'(req_r), 0);
    req_v = '0;
    tick;

    // Mixed traffic against the model
    for (int k = 0; k < 200; k++) begin
      req_v   = N'($urandom);
      ready_i = ($urandom_range(0, 3) != 0);
      pdata   = {$urandom, $urandom};
      tick;
    end
    req_v = '0; ready_i = 1'b1;
    tick; tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter m, default 8: data width per requester, in bits.
REQ-002 Parameter n, default 8: number of requesters.
REQ-003 Parameter width, default 3: select width; n SHALL be <= 2**width.
REQ-004 Parameter maxb, default 4: maximum beats per grant; maxb SHALL be >= 1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 pdata  input  n*m  parallel requester data; requester i occupies bits [m*(i+1)-1 -: m].
REQ-008 req_v  input  n  per-requester valid.
REQ-009 req_r  output  n  per-requester ready, combinational.
REQ-010 data_o  output  m  registered output beat.
REQ-011 valid_o  output  1  registered output valid.
REQ-012 ready_i  input  1  downstream ready.
REQ-013 sel_o  output  width  binary index of current grant g (registered).
REQ-014 busy_o  output  1  high while state is BUSY.

Function
REQ-015 FSM states SHALL be IDLE and BUSY; busy_o = (state==BUSY).
REQ-016 Slot free: free = !valid_o || ready_i.
REQ-017 req_r[i] SHALL be 1 only when state==BUSY, i==g and free; all other bits 0.
REQ-018 Beat accepted when req_v[g] && req_r[g]; on that edge data_o <= pdata slice g and valid_o <= 1.
REQ-019 If valid_o && ready_i and no beat accepted, valid_o SHALL go 0; data_o holds.
REQ-020 While valid_o && !ready_i, data_o and valid_o SHALL remain unchanged.
REQ-021 IDLE: if any req_v bit is set, g SHALL be the first set index searching ptr, ptr+1, ... wrapping n-1 -> 0; beat_cnt <= 0; state <= BUSY next edge; otherwise remain IDLE.
REQ-022 Arbitration costs exactly one cycle in IDLE; no beat is accepted in IDLE.
REQ-023 BUSY: each accepted beat increments beat_cnt (width clog2(maxb+1)).
REQ-024 BUSY: release when the accepted beat brings beat_cnt to maxb, or when req_v[g]==0 in any cycle.
REQ-025 On release: ptr <= (g==n-1) ? 0 : g+1; state <= IDLE.
REQ-026 A requester that deasserts req_v in the same cycle it is granted SHALL be released with zero beats.
REQ-027 Indices >= n SHALL never be granted; sel_o always < n.
REQ-028 Total latency from requester's req_v rise (idle arbiter, ptr pointing to it) to valid_o: 2 cycles.
REQ-029 req_v changes on non-granted requesters SHALL have no effect during BUSY.
REQ-030 Output beats SHALL appear in acceptance order; no beat dropped or duplicated outside reset.

Reset
REQ-031 On rst=1 at a rising edge: state=IDLE, ptr=0, g=0, sel_o=0, beat_cnt=0, valid_o=0, data_o=0, busy_o=0; req_r=0 combinationally thereafter.
REQ-032 rst SHALL take priority over every other event; a beat in the output register at reset is discarded.
REQ-033 Outputs SHALL take reset values one cycle after rst is applied, regardless of FSM state.

Verification
REQ-034 Single requester: m=8,n=8, req_v=8'h04, pdata slice 2=8'hA5, ready_i=1 -> cycle 1 busy_o=1, sel_o=2; cycle 2 valid_o=1, data_o=8'hA5; after 4 beats release, ptr=3.
REQ-035 Fairness: req_v=8'hFF held, ready_i=1, maxb=4 -> grants 0,1,2,...,7,0 in order, exactly 4 beats each, one IDLE cycle between grants.
REQ-036 Backpressure: grant 5 with valid_o=1, ready_i=0 for 3 cycles -> req_r[5]=0, data_o unchanged; ready_i=1 -> next beat accepted same edge.
REQ-037 Early release: grant 1, req_v[1] drops after 2 beats -> state IDLE, ptr=2, beat_cnt not reaching maxb.
REQ-038 Wrap-around: g=7 released, req_v=8'h81 -> next grant 0 (ptr wrapped), not 7.
REQ-039 Reset mid-burst: rst=1 while BUSY with valid_o=1 -> next cycle valid_o=0, busy_o=0, sel_o=0, req_r=0.
